// File: rtl/e203_exu_wbck_sched_if.sv
// ----------------------------------------------------------------------------
// e203_exu_wbck_sched_if
//
// Bundles every handshake and data signal of the write-back scheduler so the
// scheduler and its neighbours connect through one port.
//
//   ALU result     : alu_i_valid / alu_i_ready / alu_i_wdat / alu_i_rdidx
//   Long pipe 0    : lp0_i_valid / lp0_i_ready / lp0_i_wdat / lp0_i_itag (LSU)
//   Long pipe 1    : lp1_i_valid / lp1_i_ready / lp1_i_wdat / lp1_i_itag (MULDIV)
//   OITF head      : oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen,
//                    oitf_ret_ena (retire strobe back to the OITF)
//   Regfile write  : rf_wbck_o_valid / rf_wbck_o_ready / rf_wbck_o_wdat /
//                    rf_wbck_o_rdidx
//   Debug          : wbck_grant_src (last accepted source)
//
// Modports:
//   slave  - the scheduler itself
//   master - the surrounding EXU (or a testbench) driving the requests
// ----------------------------------------------------------------------------
interface e203_exu_wbck_sched_if #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int ITAG_W  = 2
);
    logic               alu_i_valid;
    logic               alu_i_ready;
    logic [XLEN-1:0]    alu_i_wdat;
    logic [RFIDX_W-1:0] alu_i_rdidx;

    logic               lp0_i_valid;
    logic               lp0_i_ready;
    logic [XLEN-1:0]    lp0_i_wdat;
    logic [ITAG_W-1:0]  lp0_i_itag;

    logic               lp1_i_valid;
    logic               lp1_i_ready;
    logic [XLEN-1:0]    lp1_i_wdat;
    logic [ITAG_W-1:0]  lp1_i_itag;

    logic               oitf_empty;
    logic [ITAG_W-1:0]  oitf_ret_ptr;
    logic [RFIDX_W-1:0] oitf_ret_rdidx;
    logic               oitf_ret_rdwen;
    logic               oitf_ret_ena;

    logic               rf_wbck_o_valid;
    logic               rf_wbck_o_ready;
    logic [XLEN-1:0]    rf_wbck_o_wdat;
    logic [RFIDX_W-1:0] rf_wbck_o_rdidx;

    logic [1:0]         wbck_grant_src;

    modport slave (
        input  alu_i_valid, alu_i_wdat, alu_i_rdidx,
        output alu_i_ready,
        input  lp0_i_valid, lp0_i_wdat, lp0_i_itag,
        output lp0_i_ready,
        input  lp1_i_valid, lp1_i_wdat, lp1_i_itag,
        output lp1_i_ready,
        input  oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen,
        output oitf_ret_ena,
        output rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx,
        input  rf_wbck_o_ready,
        output wbck_grant_src
    );

    modport master (
        output alu_i_valid, alu_i_wdat, alu_i_rdidx,
        input  alu_i_ready,
        output lp0_i_valid, lp0_i_wdat, lp0_i_itag,
        input  lp0_i_ready,
        output lp1_i_valid, lp1_i_wdat, lp1_i_itag,
        input  lp1_i_ready,
        output oitf_empty, oitf_ret_ptr, oitf_ret_rdidx, oitf_ret_rdwen,
        input  oitf_ret_ena,
        input  rf_wbck_o_valid, rf_wbck_o_wdat, rf_wbck_o_rdidx,
        output rf_wbck_o_ready,
        input  wbck_grant_src
    );
endinterface

// File: rtl/e203_exu_wbck_sched.sv
// ----------------------------------------------------------------------------
// e203_exu_wbck_sched
//
// Write-back scheduler for the EXU register-file write port. Arbitrates the
// single-cycle ALU result against two long-pipe requesters (LSU, MULDIV) that
// must retire in OITF order, and holds the winner in a one-entry output
// register driving the regfile write port.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - e203_exu_wbck_sched_if.slave (ALU / long-pipe requests, OITF head
//          and retire strobe, registered regfile write request, grant source)
// ----------------------------------------------------------------------------
module e203_exu_wbck_sched #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int ITAG_W     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    e203_exu_wbck_sched_if.slave          bus
);

    logic               buf_valid;
    logic [XLEN-1:0]    buf_wdat;
    logic [RFIDX_W-1:0] buf_rdidx;
    logic [1:0]         grant_src;
    logic [3:0]         starve_cnt;

    logic lp0_hit;
    logic lp1_hit;
    logic lp_hit;
    logic buf_free;
    logic alu_prio;
    logic lp_ok;
    logic lp_grant;
    logic lp_wr_grant;
    logic alu_rdy;
    logic alu_grant;

    // Only the requester whose tag matches the OITF head may retire.
    assign lp0_hit  = bus.lp0_i_valid & ~bus.oitf_empty & (bus.lp0_i_itag == bus.oitf_ret_ptr);
    assign lp1_hit  = bus.lp1_i_valid & ~bus.oitf_empty & (bus.lp1_i_itag == bus.oitf_ret_ptr);
    assign lp_hit   = lp0_hit | lp1_hit;

    assign buf_free = ~buf_valid | bus.rf_wbck_o_ready;
    assign alu_prio = (starve_cnt == 4'(STARVE_MAX));

    // A retire without a register write never needs the buffer. A writing
    // retire needs the buffer and loses it only to a valid starved ALU.
    assign lp_ok       = ~bus.oitf_ret_rdwen | (buf_free & ~(alu_prio & bus.alu_i_valid));
    assign lp_grant    = ~rst & lp_hit & lp_ok;
    assign lp_wr_grant = lp_grant & bus.oitf_ret_rdwen;

    // ALU readiness is computed from the competitor alone so it never depends
    // on alu_i_valid; this is mutually exclusive with lp_wr_grant.
    assign alu_rdy   = ~rst & buf_free & ~(lp_hit & bus.oitf_ret_rdwen & ~alu_prio);
    assign alu_grant = alu_rdy & bus.alu_i_valid;

    assign bus.alu_i_ready  = alu_rdy;
    assign bus.lp0_i_ready  = ~rst & lp0_hit & lp_ok;
    assign bus.lp1_i_ready  = ~rst & lp1_hit & ~lp0_hit & lp_ok;
    assign bus.oitf_ret_ena = lp_grant;

    // Output buffer: loads the single buffer-writing winner, drains on ready,
    // and reports which source was accepted last (ALU wins the label on a
    // dual grant because it is the one that landed in the buffer).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_wdat  <= '0;
            buf_rdidx <= '0;
            grant_src <= 2'd0;
        end else begin
            if (alu_grant) begin
                buf_valid <= 1'b1;
                buf_wdat  <= bus.alu_i_wdat;
                buf_rdidx <= bus.alu_i_rdidx;
            end else if (lp_wr_grant) begin
                buf_valid <= 1'b1;
                buf_wdat  <= lp0_hit ? bus.lp0_i_wdat : bus.lp1_i_wdat;
                buf_rdidx <= bus.oitf_ret_rdidx;
            end else if (bus.rf_wbck_o_ready) begin
                buf_valid <= 1'b0;
            end

            if (alu_grant) begin
                grant_src <= 2'd1;
            end else if (lp_grant) begin
                grant_src <= lp0_hit ? 2'd2 : 2'd3;
            end
        end
    end

    // Starvation counter: counts cycles where a waiting ALU result could have
    // used the buffer but a long-pipe took it; at STARVE_MAX the ALU wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (~bus.alu_i_valid | alu_grant) begin
            starve_cnt <= 4'd0;
        end else if (buf_free & lp_wr_grant & ~alu_prio) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign bus.rf_wbck_o_valid = buf_valid;
    assign bus.rf_wbck_o_wdat  = buf_wdat;
    assign bus.rf_wbck_o_rdidx = buf_rdidx;
    assign bus.wbck_grant_src  = grant_src;

endmodule

// File: tb/tb_e203_exu_wbck_sched.sv
// ----------------------------------------------------------------------------
// tb_e203_exu_wbck_sched
//
// Self-checking bench for the write-back scheduler: a table of single-cycle
// arbitration vectors, hand-written multi-cycle sequences (ALU latency, OITF
// ordering, starvation, back-pressure, back-to-back beats, mid-run reset) and
// a randomized run compared each cycle against a behavioural model that picks
// winners straight from the priority rules.
// ----------------------------------------------------------------------------
module tb_e203_exu_wbck_sched;

    localparam int XLEN       = 32;
    localparam int RFIDX_W    = 5;
    localparam int ITAG_W     = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    e203_exu_wbck_sched_if #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .ITAG_W(ITAG_W)) bus ();

    e203_exu_wbck_sched #(
        .XLEN(XLEN), .RFIDX_W(RFIDX_W), .ITAG_W(ITAG_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit        aluV;
        bit [31:0] aluW;
        bit [4:0]  aluRd;
        bit        v0;
        bit [31:0] w0;
        bit [1:0]  t0;
        bit        v1;
        bit [31:0] w1;
        bit [1:0]  t1;
        bit        empty;
        bit [1:0]  ptr;
        bit [4:0]  retRd;
        bit        rdwen;
        bit        rfReady;
    } stim_t;

    typedef struct packed {
        bit alu;
        bit lp0;
        bit lp1;
        bit lpBuf;
    } grant_t;

    typedef struct {
        string name;
        stim_t s;
        bit    eAlu;
        bit    eLp0;
        bit    eLp1;
        bit    eRet;
    } tvec_t;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state
    bit        mValid;
    bit [31:0] mWdat;
    bit [4:0]  mRd;
    bit [1:0]  mSrc;
    int        mStarve;
    stim_t     cur;
    grant_t    lastG;
    bit [1:0]  headPtr;
    bit [4:0]  headRd;
    bit        headWen;

    tvec_t tab[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        cur = s;
        bus.alu_i_valid     = s.aluV;
        bus.alu_i_wdat      = s.aluW;
        bus.alu_i_rdidx     = s.aluRd;
        bus.lp0_i_valid     = s.v0;
        bus.lp0_i_wdat      = s.w0;
        bus.lp0_i_itag      = s.t0;
        bus.lp1_i_valid     = s.v1;
        bus.lp1_i_wdat      = s.w1;
        bus.lp1_i_itag      = s.t1;
        bus.oitf_empty      = s.empty;
        bus.oitf_ret_ptr    = s.ptr;
        bus.oitf_ret_rdidx  = s.retRd;
        bus.oitf_ret_rdwen  = s.rdwen;
        bus.rf_wbck_o_ready = s.rfReady;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.rfReady = 1'b1;
        s.ptr     = headPtr;
        s.retRd   = headRd;
        s.rdwen   = headWen;
        return s;
    endfunction

    // Winner selection written straight from the arbitration rules: the head
    // match decides the long-pipe candidate (LP0 first), a non-writing retire
    // leaves the buffer to the ALU, otherwise the buffer goes to the long-pipe
    // unless the ALU is starved.
    function automatic grant_t decide(input bit aluV);
        grant_t g;
        bit h0, h1, free;
        g    = '0;
        h0   = cur.v0 && !cur.empty && (cur.t0 == cur.ptr);
        h1   = cur.v1 && !cur.empty && (cur.t1 == cur.ptr);
        free = !mValid || cur.rfReady;
        if ((h0 || h1) && !cur.rdwen) begin
            g.lp0 = h0;
            g.lp1 = !h0 && h1;
            g.alu = aluV && free;
        end else if (h0 || h1) begin
            if (free) begin
                if (aluV && mStarve == STARVE_MAX) begin
                    g.alu = 1'b1;
                end else begin
                    g.lp0   = h0;
                    g.lp1   = !h0;
                    g.lpBuf = 1'b1;
                end
            end
        end else begin
            g.alu = aluV && free;
        end
        return g;
    endfunction

    task automatic modelReset();
        mValid  = 1'b0;
        mWdat   = '0;
        mRd     = '0;
        mSrc    = 2'd0;
        mStarve = 0;
        headPtr = 2'd0;
        headRd  = 5'd1;
        headWen = 1'b1;
    endtask

    // One clock: compare every output with the model, take the edge, advance
    // the model and the OITF head.
    task automatic cycle();
        grant_t g, gr;
        bit free;
        #1;
        g  = decide(cur.aluV);
        gr = decide(1'b1);
        checkOutput("alu_i_ready", bus.alu_i_ready, gr.alu);
        checkOutput("lp0_i_ready", bus.lp0_i_ready, g.lp0);
        checkOutput("lp1_i_ready", bus.lp1_i_ready, g.lp1);
        checkOutput("oitf_ret_ena", bus.oitf_ret_ena, g.lp0 | g.lp1);
        checkOutput("rf_wbck_o_valid", bus.rf_wbck_o_valid, mValid);
        if (mValid) begin
            checkOutput("rf_wbck_o_wdat", bus.rf_wbck_o_wdat, mWdat);
            checkOutput("rf_wbck_o_rdidx", bus.rf_wbck_o_rdidx, mRd);
        end
        checkOutput("wbck_grant_src", bus.wbck_grant_src, mSrc);
        @(posedge clk);
        free = !mValid || cur.rfReady;
        if (!cur.aluV || g.alu)                           mStarve = 0;
        else if (free && g.lpBuf && mStarve < STARVE_MAX) mStarve = mStarve + 1;
        if (g.alu) begin
            mValid = 1'b1; mWdat = cur.aluW; mRd = cur.aluRd;
        end else if (g.lpBuf) begin
            mValid = 1'b1; mWdat = g.lp0 ? cur.w0 : cur.w1; mRd = cur.retRd;
        end else if (cur.rfReady) begin
            mValid = 1'b0;
        end
        if (g.alu)      mSrc = 2'd1;
        else if (g.lp0) mSrc = 2'd2;
        else if (g.lp1) mSrc = 2'd3;
        if (g.lp0 || g.lp1) begin
            headPtr = headPtr + 2'd1;
            headRd  = 5'($urandom);
            headWen = 1'($urandom);
        end
        lastG = g;
        @(negedge clk);
    endtask

    task automatic doReset();
        stim_t s;
        s = idle();
        s.aluV = 1'b1;
        rst = 1'b1;
        applyStimulus(s);
        #1;
        checkOutput("reset alu_i_ready", bus.alu_i_ready, 0);
        checkOutput("reset rf_wbck_o_valid", bus.rf_wbck_o_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelReset();
        applyStimulus(idle());
        rst = 1'b0;
    endtask

    function automatic tvec_t mkVec(input string name, input bit aluV, input bit v0, input bit [1:0] t0,
                                    input bit v1, input bit [1:0] t1, input bit empty, input bit [1:0] ptr,
                                    input bit rdwen, input bit eAlu, input bit eLp0, input bit eLp1, input bit eRet);
        tvec_t v;
        v.name    = name;
        v.s       = '{default: '0};
        v.s.aluV  = aluV;  v.s.aluW = 32'h1000_0000 | 32'(t0); v.s.aluRd = 5'd2;
        v.s.v0    = v0;    v.s.t0 = t0; v.s.w0 = 32'hA0A0_0000;
        v.s.v1    = v1;    v.s.t1 = t1; v.s.w1 = 32'hB0B0_0000;
        v.s.empty = empty; v.s.ptr = ptr; v.s.retRd = 5'd12; v.s.rdwen = rdwen;
        v.s.rfReady = 1'b1;
        v.eAlu = eAlu; v.eLp0 = eLp0; v.eLp1 = eLp1; v.eRet = eRet;
        return v;
    endfunction

    initial begin
        stim_t s;
        modelReset();
        applyStimulus(idle());
        doReset();

        checkOutput("reset rf_wbck_o_wdat", bus.rf_wbck_o_wdat, 0);
        checkOutput("reset rf_wbck_o_rdidx", bus.rf_wbck_o_rdidx, 0);
        checkOutput("reset wbck_grant_src", bus.wbck_grant_src, 0);

        // ---- ALU request latency ----
        s = idle(); s.aluV = 1'b1; s.aluW = 32'hDEADBEEF; s.aluRd = 5'd5;
        applyStimulus(s);
        #1;
        checkOutput("alu first ready", bus.alu_i_ready, 1);
        checkOutput("alu first ret_ena", bus.oitf_ret_ena, 0);
        cycle();
        applyStimulus(idle());
        #1;
        checkOutput("alu beat valid", bus.rf_wbck_o_valid, 1);
        checkOutput("alu beat wdat", bus.rf_wbck_o_wdat, 32'hDEADBEEF);
        checkOutput("alu beat rdidx", bus.rf_wbck_o_rdidx, 5);
        checkOutput("alu beat src", bus.wbck_grant_src, 1);
        cycle();

        // ---- arbitration table ----
        tab[0] = mkVec("alu only",        1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0);
        tab[1] = mkVec("lp0 beats alu",   1, 1, 1, 0, 0, 0, 1, 1,  0, 1, 0, 1);
        tab[2] = mkVec("lp1 hit",         0, 0, 0, 1, 2, 0, 2, 1,  0, 0, 1, 1);
        tab[3] = mkVec("dup tag lp0",     0, 1, 3, 1, 3, 0, 3, 1,  0, 1, 0, 1);
        tab[4] = mkVec("dual grant",      1, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1);
        tab[5] = mkVec("oitf empty",      1, 1, 2, 1, 2, 1, 2, 1,  1, 0, 0, 0);
        tab[6] = mkVec("tag miss",        1, 1, 1, 0, 0, 0, 2, 1,  1, 0, 0, 0);
        tab[7] = mkVec("no valids",       0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tab[i].s);
            #1;
            checkOutput({tab[i].name, " alu_i_ready"}, bus.alu_i_ready, tab[i].eAlu);
            checkOutput({tab[i].name, " lp0_i_ready"}, bus.lp0_i_ready, tab[i].eLp0);
            checkOutput({tab[i].name, " lp1_i_ready"}, bus.lp1_i_ready, tab[i].eLp1);
            checkOutput({tab[i].name, " oitf_ret_ena"}, bus.oitf_ret_ena, tab[i].eRet);
            cycle();
            applyStimulus(idle());
            cycle();
        end

        // ---- OITF ordering: head tag 2 selects lp1 over lp0 ----
        s = idle(); s.ptr = 2; s.retRd = 7; s.rdwen = 1;
        s.v1 = 1; s.t1 = 2; s.w1 = 32'h1111_2222; s.v0 = 1; s.t0 = 3;
        applyStimulus(s);
        #1;
        checkOutput("order lp1_i_ready", bus.lp1_i_ready, 1);
        checkOutput("order lp0_i_ready", bus.lp0_i_ready, 0);
        checkOutput("order oitf_ret_ena", bus.oitf_ret_ena, 1);
        cycle();
        s.empty = 1;
        applyStimulus(s);
        #1;
        checkOutput("order rdidx", bus.rf_wbck_o_rdidx, 7);
        checkOutput("order src", bus.wbck_grant_src, 3);
        checkOutput("empty lp1_i_ready", bus.lp1_i_ready, 0);
        checkOutput("empty oitf_ret_ena", bus.oitf_ret_ena, 0);
        cycle();
        applyStimulus(idle());
        cycle();

        // ---- starvation: four long-pipe wins, then the ALU, then long-pipe again ----
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.aluV = 1; s.aluW = 32'(100 + i); s.aluRd = 5'd1;
            s.v0 = 1; s.t0 = headPtr; s.w0 = 32'(200 + i); s.rdwen = 1; s.retRd = 5'd9;
            applyStimulus(s);
            #1;
            checkOutput("starve alu_i_ready", bus.alu_i_ready, (i == 4));
            checkOutput("starve lp0_i_ready", bus.lp0_i_ready, (i != 4));
            cycle();
            if (i == 4) begin
                #1;
                checkOutput("starve alu wdat", bus.rf_wbck_o_wdat, 104);
                checkOutput("starve alu src", bus.wbck_grant_src, 1);
            end
        end
        applyStimulus(idle());
        cycle();

        // ---- back-pressure: writing grants stall, a rdwen=0 retire proceeds ----
        s = idle(); s.aluV = 1; s.aluW = 32'h5A5A_0001; s.aluRd = 5'd11;
        applyStimulus(s);
        cycle();
        s = idle(); s.rfReady = 0; s.aluV = 1; s.aluW = 32'h5A5A_0002;
        s.v1 = 1; s.t1 = headPtr; s.rdwen = 1;
        applyStimulus(s);
        #1;
        checkOutput("stall alu_i_ready", bus.alu_i_ready, 0);
        checkOutput("stall lp1_i_ready", bus.lp1_i_ready, 0);
        checkOutput("stall oitf_ret_ena", bus.oitf_ret_ena, 0);
        cycle();
        s = idle(); s.rfReady = 0; s.aluV = 1; s.v0 = 1; s.t0 = headPtr; s.rdwen = 0;
        applyStimulus(s);
        #1;
        checkOutput("stall hold wdat", bus.rf_wbck_o_wdat, 32'h5A5A_0001);
        checkOutput("stall hold rdidx", bus.rf_wbck_o_rdidx, 11);
        checkOutput("nowrite lp0_i_ready", bus.lp0_i_ready, 1);
        checkOutput("nowrite oitf_ret_ena", bus.oitf_ret_ena, 1);
        checkOutput("nowrite alu_i_ready", bus.alu_i_ready, 0);
        cycle();
        applyStimulus(idle());
        cycle();
        cycle();

        // ---- back-to-back ALU, LP0, ALU ----
        s = idle(); s.aluV = 1; s.aluW = 32'hAAAA_0001; s.aluRd = 5'd3;
        applyStimulus(s);
        cycle();
        s = idle(); s.v0 = 1; s.t0 = headPtr; s.ptr = headPtr; s.w0 = 32'hBBBB_0002;
        s.retRd = 5'd4; s.rdwen = 1;
        applyStimulus(s);
        #1;
        checkOutput("b2b beat1 wdat", bus.rf_wbck_o_wdat, 32'hAAAA_0001);
        checkOutput("b2b beat1 rdidx", bus.rf_wbck_o_rdidx, 3);
        cycle();
        s = idle(); s.aluV = 1; s.aluW = 32'hCCCC_0003; s.aluRd = 5'd6;
        applyStimulus(s);
        #1;
        checkOutput("b2b beat2 valid", bus.rf_wbck_o_valid, 1);
        checkOutput("b2b beat2 wdat", bus.rf_wbck_o_wdat, 32'hBBBB_0002);
        checkOutput("b2b beat2 rdidx", bus.rf_wbck_o_rdidx, 4);
        cycle();
        applyStimulus(idle());
        #1;
        checkOutput("b2b beat3 valid", bus.rf_wbck_o_valid, 1);
        checkOutput("b2b beat3 wdat", bus.rf_wbck_o_wdat, 32'hCCCC_0003);
        cycle();

        // ---- reset while the buffer holds a result ----
        s = idle(); s.aluV = 1; s.aluW = 32'h7777_7777; s.aluRd = 5'd8;
        applyStimulus(s);
        cycle();
        s = idle(); s.rfReady = 0;
        applyStimulus(s);
        #1;
        checkOutput("pre-reset valid", bus.rf_wbck_o_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("async reset valid", bus.rf_wbck_o_valid, 0);
        checkOutput("async reset wdat", bus.rf_wbck_o_wdat, 0);
        @(negedge clk);
        modelReset();
        applyStimulus(idle());
        rst = 1'b0;
        cycle();
        cycle();

        // ---- randomized run against the model ----
        for (int n = 0; n < 1500; n++) begin
            s = '{default: '0};
            s.aluV    = 1'($urandom);
            s.aluW    = $urandom;
            s.aluRd   = 5'($urandom);
            s.v0      = 1'($urandom);
            s.w0      = $urandom;
            s.t0      = ($urandom_range(0, 2) == 0) ? 2'($urandom) : headPtr;
            s.v1      = 1'($urandom);
            s.w1      = $urandom;
            s.t1      = ($urandom_range(0, 2) == 0) ? 2'($urandom) : headPtr + 2'd1;
            if ($urandom_range(0, 3) == 0) s.t1 = headPtr;
            s.empty   = ($urandom_range(0, 7) == 0);
            s.ptr     = headPtr;
            s.retRd   = headRd;
            s.rdwen   = headWen;
            s.rfReady = ($urandom_range(0, 3) != 0);
            applyStimulus(s);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
